// File: rtl/div_pkg.sv
// Shared definitions for the divide unit and its EX-stage issue controller.
package div_pkg;

  localparam int   RegWidth       = 32;
  localparam int   DoubleRegWidth = 2 * RegWidth;
  localparam logic RstEnable      = 1'b1;

  // The divider's own states; the issue controller only watches its done flag.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DONE  = 2'b10,
    DRAIN = 2'b11
  } issue_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage start/cancel/done handshake for the iterative divider: captures
// operands, stalls until the result arrives, then presents the HI/LO write.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int REG_W = RegWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_div_op,
  input  logic               ex_div_signed,
  input  logic [REG_W-1:0]   ex_rs_data,
  input  logic [REG_W-1:0]   ex_rt_data,
  input  logic               ex_flush,
  input  logic               stall_from_later,
  output logic               div_start,
  output logic               div_cancel,
  output logic               signed_div,
  output logic [REG_W-1:0]   div_opdata1,
  output logic [REG_W-1:0]   div_opdata2,
  input  logic [2*REG_W-1:0] div_res,
  input  logic               div_done,
  output logic               ex_stall_req,
  output logic               hilo_we,
  output logic [REG_W-1:0]   hi_wdata,
  output logic [REG_W-1:0]   lo_wdata
);

  issue_state_e      state_q,     state_d;
  logic              divStart_q,  divStart_d;
  logic              divCancel_q, divCancel_d;
  logic              signedDiv_q, signedDiv_d;
  logic [REG_W-1:0]  opA_q,       opA_d;
  logic [REG_W-1:0]  opB_q,       opB_d;
  logic [REG_W-1:0]  hiData_q,    hiData_d;
  logic [REG_W-1:0]  loData_q,    loData_d;
  logic              drainCnt_q,  drainCnt_d;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= IDLE;
      divStart_q  <= 1'b0;
      divCancel_q <= 1'b0;
      signedDiv_q <= 1'b0;
      opA_q       <= '0;
      opB_q       <= '0;
      hiData_q    <= '0;
      loData_q    <= '0;
      drainCnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      divStart_q  <= divStart_d;
      divCancel_q <= divCancel_d;
      signedDiv_q <= signedDiv_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      hiData_q    <= hiData_d;
      loData_q    <= loData_d;
      drainCnt_q  <= drainCnt_d;
    end
  end

  // A done seen in IDLE is a leftover from the previous divide and is ignored.
  always_comb begin
    state_d     = state_q;
    divStart_d  = divStart_q;
    divCancel_d = divCancel_q;
    signedDiv_d = signedDiv_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    hiData_d    = hiData_q;
    loData_d    = loData_q;
    drainCnt_d  = drainCnt_q;

    unique case (state_q)
      IDLE: begin
        if (ex_div_op && !ex_flush) begin
          opA_d       = ex_rs_data;
          opB_d       = ex_rt_data;
          signedDiv_d = ex_div_signed;
          divStart_d  = 1'b1;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (ex_flush) begin
          divStart_d  = 1'b0;
          divCancel_d = 1'b1;
          drainCnt_d  = 1'b0;
          state_d     = DRAIN;
        end else if (div_done) begin
          hiData_d = div_res[2*REG_W-1:REG_W];
          loData_d = div_res[REG_W-1:0];
          state_d  = DONE;
        end
      end

      // Start stays high here so the divider keeps presenting its result.
      DONE: begin
        if (ex_flush || !stall_from_later) begin
          divStart_d = 1'b0;
          state_d    = IDLE;
        end
      end

      // Two cancel cycles let a zero-divisor divide pass through its end state.
      DRAIN: begin
        if (drainCnt_q) begin
          divCancel_d = 1'b0;
          drainCnt_d  = 1'b0;
          state_d     = IDLE;
        end else begin
          drainCnt_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_stall_req = !ex_flush &&
                   (((state_q == IDLE) && ex_div_op) ||
                    (state_q == BUSY) || (state_q == DRAIN));
    hilo_we      = (state_q == DONE) && !ex_flush;
  end

  assign div_start   = divStart_q;
  assign div_cancel  = divCancel_q;
  assign signed_div  = signedDiv_q;
  assign div_opdata1 = opA_q;
  assign div_opdata2 = opB_q;
  assign hi_wdata    = hiData_q;
  assign lo_wdata    = loData_q;

endmodule
